// File: rtl/write_buffer_wt_pkg.sv
// Shared types and default sizes for the write-through write buffer.
package write_buffer_wt_pkg;

    localparam int unsigned WB_DEPTH_DEF  = 4;
    localparam int unsigned WB_DATA_W_DEF = 32;
    localparam int unsigned WB_ADDR_W_DEF = 32;
    localparam int unsigned WB_WADDR_W    = WB_ADDR_W_DEF - 2;

    // Drain FSM: IDLE waits for a buffered write, REQ holds it on the memory port.
    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } wb_state_e;

    // One buffer slot: word address (byte offset dropped) and its data.
    typedef struct packed {
        logic                     valid;
        logic [WB_WADDR_W-1:0]    waddr;
        logic [WB_DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/write_buffer_match.sv
// Youngest-match search over the circular buffer, scanning from head (oldest) to tail.
module write_buffer_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned KEY_W = 30,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [KEY_W-1:0] key_arr_i [DEPTH],
    input  logic [PTR_W-1:0] head_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             hit_o,
    output logic [PTR_W-1:0] idx_o
);

    logic [PTR_W-1:0] slot;

    // Later (younger) hits in age order override earlier ones.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        slot  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (valid_i[slot] && (key_arr_i[slot] == key_i)) begin
                hit_o = 1'b1;
                idx_o = slot;
            end
        end
    end

endmodule

// File: rtl/write_buffer_wt.sv
// Write-through write buffer: coalesces, forwards to read misses, drains in order to memory.
module write_buffer_wt
    import write_buffer_wt_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH_DEF,
    parameter int unsigned DATA_W = WB_DATA_W_DEF,
    parameter int unsigned ADDR_W = WB_ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_match,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       mem_req,
    input  logic                       mem_ack,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        entries_q [DEPTH];
    wb_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;

    logic [DEPTH-1:0]      valid_vec;
    logic [WB_WADDR_W-1:0] waddr_arr [DEPTH];
    logic [WB_WADDR_W-1:0] wr_waddr, rd_waddr;
    logic                  fwd_hit, co_hit;
    logic [PTR_W-1:0]      fwd_idx, co_idx;
    logic                  accept, pop, coalesce, enq, full_w, req_w;
    logic                  unused_addr_lsbs;

    assign wr_waddr         = WB_WADDR_W'(wr_addr[ADDR_W-1:2]);
    assign rd_waddr         = WB_WADDR_W'(rd_addr[ADDR_W-1:2]);
    assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

    // Flatten slot keys for the match searches.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries_q[i].valid;
            waddr_arr[i] = entries_q[i].waddr;
        end
    end

    write_buffer_match #(.DEPTH(DEPTH), .KEY_W(WB_WADDR_W), .PTR_W(PTR_W)) u_fwd (
        .valid_i   (valid_vec),
        .key_arr_i (waddr_arr),
        .head_i    (head_q),
        .key_i     (rd_waddr),
        .hit_o     (fwd_hit),
        .idx_o     (fwd_idx)
    );

    write_buffer_match #(.DEPTH(DEPTH), .KEY_W(WB_WADDR_W), .PTR_W(PTR_W)) u_coal (
        .valid_i   (valid_vec),
        .key_arr_i (waddr_arr),
        .head_i    (head_q),
        .key_i     (wr_waddr),
        .hit_o     (co_hit),
        .idx_o     (co_idx)
    );

    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign req_w    = (state_q == WB_REQ);
    assign accept   = wr_valid && !full_w;
    assign pop      = req_w && mem_ack;
    // The in-flight head must not change under the memory port.
    assign coalesce = accept && co_hit && !((co_idx == head_q) && req_w);
    assign enq      = accept && !coalesce;

    // Drain FSM next state and memory-port capture.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            WB_IDLE: begin
                if (count_q != '0) begin
                    state_d    = WB_REQ;
                    mem_addr_d = ADDR_W'({entries_q[head_q].waddr, 2'b00});
                    // A write coalescing into the head this edge must reach memory.
                    mem_data_d = (coalesce && (co_idx == head_q)) ? wr_data
                                                                  : DATA_W'(entries_q[head_q].data);
                end
            end
            WB_REQ: begin
                if (mem_ack) state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Buffer storage, pointers and occupancy.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (coalesce) begin
            entries_d[co_idx].data = WB_DATA_W_DEF'(wr_data);
        end
        if (enq) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].waddr = wr_waddr;
            entries_d[tail_q].data  = WB_DATA_W_DEF'(wr_data);
            tail_d                  = tail_q + PTR_W'(1);
        end
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= WB_IDLE;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign wr_ready = !full_w;
    assign full     = full_w;
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign idle     = (count_q == '0) && (state_q == WB_IDLE);
    assign mem_req  = req_w;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign rd_match = fwd_hit;
    assign rd_data  = fwd_hit ? DATA_W'(entries_q[fwd_idx].data) : '0;

endmodule

// File: tb/tb_write_buffer_wt.sv
// Directed self-checking bench for write_buffer_wt.
module tb_write_buffer_wt;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic        rd_match;
    logic [31:0] rd_data;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_data;
    logic        full, empty, idle;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    write_buffer_wt dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_match (rd_match),
        .rd_data  (rd_data),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 8) begin
            tick();
            n++;
        end
        chk("req_wait", 64'(mem_req), 64'd1);
    endtask

    task automatic drain_one(input string tag, input logic [31:0] ea, input logic [31:0] ed);
        wait_req();
        chk({tag, "_addr"}, 64'(mem_addr), 64'(ea));
        chk({tag, "_data"}, 64'(mem_data), 64'(ed));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_mem_req",  64'(mem_req),  64'd0);
        chk("rst_full",     64'(full),     64'd0);
        chk("rst_empty",    64'(empty),    64'd1);
        chk("rst_idle",     64'(idle),     64'd1);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_rd_match", 64'(rd_match), 64'd0);
        chk("rst_rd_data",  64'(rd_data),  64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_data", 64'(mem_data), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        reset = 1'b1;
        tick();

        // Single write: mem_req one cycle after acceptance
        wr_valid = 1'b1; wr_addr = 32'h100; wr_data = 32'hAAAA_0001;
        #1 chk("t1_wr_ready", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        chk("t1_count1",   64'(count),   64'd1);
        chk("t1_req_low",  64'(mem_req), 64'd0);
        tick();
        chk("t1_req_high", 64'(mem_req), 64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h100);
        chk("t1_mem_data", 64'(mem_data), 64'hAAAA_0001);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t1_empty",   64'(empty),   64'd1);
        chk("t1_idle",    64'(idle),    64'd1);
        chk("t1_req_off", 64'(mem_req), 64'd0);

        // Fill to full, refuse a fifth write, drain in order
        for (int i = 0; i < 4; i++) do_write(32'(32'h400 + 4 * i), 32'(i + 1));
        chk("t2_full",     64'(full),     64'd1);
        chk("t2_wr_ready", 64'(wr_ready), 64'd0);
        chk("t2_count4",   64'(count),    64'd4);
        wr_valid = 1'b1; wr_addr = 32'h410; wr_data = 32'd5;
        tick();
        chk("t2_no_admit", 64'(count), 64'd4);
        chk("t2_head_addr", 64'(mem_addr), 64'h400);
        chk("t2_head_data", 64'(mem_data), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; wr_valid = 1'b0;
        chk("t2_pop_full_no_admit", 64'(count), 64'd3);
        for (int i = 1; i < 4; i++) drain_one("t2_drain", 32'(32'h400 + 4 * i), 32'(i + 1));
        chk("t2_empty", 64'(empty), 64'd1);

        // Coalescing behind a stalled head; stray ack while idle is ignored
        do_write(32'h200, 32'h11);
        mem_ack = 1'b1;
        do_write(32'h204, 32'h22);
        mem_ack = 1'b0;
        chk("t3_ack_ignored", 64'(count), 64'd2);
        do_write(32'h204, 32'h33);
        chk("t3_coalesce_count", 64'(count), 64'd2);
        drain_one("t3_d0", 32'h200, 32'h11);
        drain_one("t3_d1", 32'h204, 32'h33);
        chk("t3_empty", 64'(empty), 64'd1);

        // Forwarding, including youngest-wins with the head in flight
        do_write(32'h300, 32'h55);
        rd_addr = 32'h300;
        #1;
        chk("t4_match",      64'(rd_match), 64'd1);
        chk("t4_data",       64'(rd_data),  64'h55);
        rd_addr = 32'h304;
        #1;
        chk("t4_nomatch",    64'(rd_match), 64'd0);
        chk("t4_nodata",     64'(rd_data),  64'd0);
        rd_addr = 32'h300;
        wait_req();
        do_write(32'h300, 32'h66);
        chk("t4_dup_count",  64'(count),    64'd2);
        chk("t4_youngest",   64'(rd_data),  64'h66);
        chk("t4_head_hold",  64'(mem_data), 64'h55);
        drain_one("t4_d0", 32'h300, 32'h55);
        drain_one("t4_d1", 32'h300, 32'h66);
        chk("t4_empty", 64'(empty), 64'd1);
        rd_addr = '0;

        // Simultaneous enqueue and pop at count 2
        do_write(32'h500, 32'hA);
        do_write(32'h504, 32'hB);
        chk("t5_count2",   64'(count),   64'd2);
        chk("t5_req",      64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        do_write(32'h508, 32'hC);
        mem_ack = 1'b0;
        chk("t5_count_same", 64'(count), 64'd2);
        drain_one("t5_d0", 32'h504, 32'hB);
        drain_one("t5_d1", 32'h508, 32'hC);
        chk("t5_empty", 64'(empty), 64'd1);

        // Reset during REQ with ack on the reset edge
        do_write(32'h600, 32'h77);
        wait_req();
        mem_ack = 1'b1; reset = 1'b0;
        tick();
        mem_ack = 1'b0; reset = 1'b1;
        chk("t6_req_low",  64'(mem_req),  64'd0);
        chk("t6_count0",   64'(count),    64'd0);
        chk("t6_empty",    64'(empty),    64'd1);
        chk("t6_mem_addr", 64'(mem_addr), 64'd0);
        repeat (2) tick();
        chk("t6_req_stays", 64'(mem_req), 64'd0);
        chk("t6_no_under",  64'(count),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_buffer_wt.md
WRITE_BUFFER_WT -- requirements
Module: write_buffer_wt

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffer entries (power of two, at least 2).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of a write data word.
REQ-003 The block SHALL have parameter ADDR_W, default 32, meaning the width of a byte address.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, a synchronous, active-low reset.
REQ-006 The block SHALL have ports wr_valid (input, 1) and wr_ready (output, 1), forming the write-through handshake from the cache.
REQ-007 The block SHALL have ports wr_addr (input, ADDR_W) and wr_data (input, DATA_W), the address and data of an incoming write.
REQ-008 The block SHALL have port rd_addr (input, ADDR_W), the address of a cache read miss to look up in the buffer.
REQ-009 The block SHALL have ports rd_match (output, 1) and rd_data (output, DATA_W), the forwarded result of that lookup.
REQ-010 The block SHALL have ports mem_req (output, 1) and mem_ack (input, 1), the main-memory write handshake.
REQ-011 The block SHALL have ports mem_addr (output, ADDR_W) and mem_data (output, DATA_W), the write presented to main memory.
REQ-012 The block SHALL have status outputs full (1), empty (1) and count ($clog2(DEPTH+1) bits), plus idle (1), defined as empty and FSM in IDLE.

Function
REQ-013 wr_ready SHALL equal !full, with no combinational path from wr_valid or wr_addr.
REQ-014 A write SHALL be accepted on any edge where wr_valid && wr_ready.
REQ-015 An accepted write whose word address (addr[ADDR_W-1:2]) matches a valid entry SHALL overwrite that entry's data in place, without changing count, provided that entry is not the head with mem_req asserted (coalescing).
REQ-016 All other accepted writes SHALL enqueue at the tail, incrementing count.
REQ-017 Lookup SHALL be combinational: rd_match is 1 when any valid entry's word address equals rd_addr's word address.
REQ-018 On a lookup match, rd_data SHALL be the data of the youngest matching entry; with no match, rd_data SHALL be 0.
REQ-019 A write accepted at edge N SHALL be visible to lookup from edge N onward.
REQ-020 The drain FSM SHALL have states IDLE and REQ, with mem_req registered and equal to (state==REQ).
REQ-021 The FSM SHALL move IDLE->REQ at the first edge where count>0, so a write into an empty buffer raises mem_req one cycle after acceptance.
REQ-022 In REQ, mem_addr and mem_data SHALL hold the head entry and stay stable until mem_ack.
REQ-023 On an edge where mem_req && mem_ack, the head SHALL pop, count SHALL decrement, and the FSM SHALL return to IDLE (one bubble cycle between memory writes).
REQ-024 mem_ack while mem_req is low SHALL be ignored.
REQ-025 A simultaneous enqueue and pop on the same edge SHALL leave count unchanged, with both pointers advancing.
REQ-026 Because wr_ready is low while full, a pop on the same edge as a full condition SHALL NOT admit a write in that cycle.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-028 Memory writes SHALL leave in acceptance order, with coalescing preserving the original slot's position.

Reset
REQ-029 While reset==0 at an edge, the block SHALL clear count and pointers, mark all entries invalid, and set the FSM to IDLE.
REQ-030 After reset, outputs SHALL read mem_req=0, full=0, empty=1, idle=1, count=0, rd_match=0, rd_data=0, mem_addr=0, mem_data=0.
REQ-031 A reset during REQ SHALL discard the in-flight write, so mem_req is low after that edge; a mem_ack on the reset edge SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (WB_IDLE, WB_REQ), the entry struct (valid, word address, data) and default parameter constants.
REQ-033 Youngest-match priority lookup SHALL be a sub-module, write_buffer_match, reused for both forwarding and coalescing.

Verification
REQ-034 Verification SHALL cover: reset, then write 0x100/0xAAAA_0001 -> wr_ready=1, mem_req=1 the next cycle, mem_addr=0x100, mem_data=0xAAAA_0001; on mem_ack, empty=1 and idle=1 one cycle later.
REQ-035 Verification SHALL cover: with mem_ack held 0, write 4 distinct addresses -> full=1, wr_ready=0, count=4; a 5th wr_valid is not accepted; writes drain in order on acks.
REQ-036 Verification SHALL cover: write 0x200=0x11 then 0x204=0x22 then 0x204=0x33 while the head is stalled -> count=2, and the drained data for 0x204 is 0x33.
REQ-037 Verification SHALL cover: with 0x300=0x55 buffered, set rd_addr=0x300 -> rd_match=1, rd_data=0x55; rd_addr=0x304 -> rd_match=0, rd_data=0.
REQ-038 Verification SHALL cover: at count=2, enqueue and ack on the same edge -> count stays 2 and order is preserved.
REQ-039 Verification SHALL cover: assert reset with mem_req=1 and mem_ack=1 -> next cycle mem_req=0, count=0, and no pop beyond the reset.
